i2s_tx_serializer: RTL and testbench

Stereo I2S transmitter that returns filtered audio to the codec DAC. It accepts a left/right 16-bit sample pair from the filter chain and generates BCLK and LRCLK as clock master, all derived from the system clock. It serializes the pair MSB-first in standard Philips I2S framing. A one-frame holding register decouples the filter's sample timing from the serial frame, and the block flags underrun and overrun.

---
 rtl/i2s_tx_serializer.sv | 178 +++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Stereo I2S master transmitter. Generates BCLK/LRCLK from clk and
//   serializes a left/right sample pair MSB-first in Philips I2S framing.
//   A one-frame holding register decouples the filter's sample timing
//   from the serial frame. Underrun and overrun are flagged with pulses.
//
// Ports
//   clk           in   system clock (sole clock)
//   reset         in   synchronous, active-high reset
//   sample_l      in   left sample, SAMPLE_W bits, two's complement
//   sample_r      in   right sample, SAMPLE_W bits, two's complement
//   sample_valid  in   one-cycle strobe, writes the pair to the holding register
//   bclk          out  bit clock, period 2*CLK_DIV clk
//   lrclk         out  word select, 0 = left, 1 = right
//   sdata         out  serial data, updated on BCLK falling events
//   frame_start   out  one-cycle pulse when a frame is loaded
//   underrun      out  one-cycle pulse: frame loaded with no new pair (replay)
//   overrun       out  one-cycle pulse: pair written over an unsent pair
module i2s_tx_serializer #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16,
    parameter int SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun,
    output logic                overrun
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SLOT_W);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_W - 1);
    localparam logic [BW-1:0] BIT_START = BW'(SLOT_W - 2);
    localparam logic [BW-1:0] DATA_BITS = BW'(SAMPLE_W);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_cnt_en;

    logic [DW-1:0]       r_div;
    logic [BW-1:0]       r_bit;
    logic                r_bclk;
    logic                r_lrclk;
    logic                r_sdata;
    logic [SAMPLE_W-1:0] r_hold_l;
    logic [SAMPLE_W-1:0] r_hold_r;
    logic                r_hold_full;
    logic [SAMPLE_W-1:0] r_sh_l;
    logic [SAMPLE_W-1:0] r_sh_r;
    logic                r_frame_start;
    logic                r_underrun;
    logic                r_overrun;

    logic                w_div_wrap;
    logic                w_fall;
    logic [BW-1:0]       w_bit_next;
    logic                w_slot_end;
    logic                w_load;
    logic                w_data_bit;

    // IDLE is the first cycle after reset release. Counting already runs
    // there so the BCLK phase is referenced directly to reset release.
    always_comb begin
        w_state_next = r_state;
        w_cnt_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_RUN;
                w_cnt_en     = 1'b1;
            end
            S_RUN: begin
                w_state_next = S_RUN;
                w_cnt_en     = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_div_wrap = w_cnt_en && (r_div == DIV_LAST);
    assign w_fall     = w_div_wrap && r_bclk;
    assign w_bit_next = (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
    assign w_slot_end = (w_bit_next == BIT_LAST);
    // Frame boundary: the falling event on which LRCLK returns to left.
    assign w_load     = w_fall && w_slot_end && r_lrclk;
    assign w_data_bit = (w_bit_next < DATA_BITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_div         <= '0;
            r_bit         <= BIT_START;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b1;
            r_sdata       <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_hold_full   <= 1'b0;
            r_sh_l        <= '0;
            r_sh_r        <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_overrun     <= 1'b0;

            if (w_cnt_en) begin
                r_div <= w_div_wrap ? '0 : r_div + 1'b1;
            end
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end

            if (w_fall) begin
                r_bit   <= w_bit_next;
                r_sdata <= 1'b0;
                if (w_slot_end) begin
                    r_lrclk <= ~r_lrclk;
                end
                // Data bits never coincide with an LRCLK toggle, so the
                // current LRCLK selects the channel. The shift registers
                // are left-shifted so the active bit is always the MSB.
                if (w_data_bit) begin
                    if (!r_lrclk) begin
                        r_sdata <= r_sh_l[SAMPLE_W-1];
                        r_sh_l  <= r_sh_l << 1;
                    end else begin
                        r_sdata <= r_sh_r[SAMPLE_W-1];
                        r_sh_r  <= r_sh_r << 1;
                    end
                end
            end

            // Holding contents survive a load, so an underrun replays the
            // last pair simply by reloading them.
            if (w_load) begin
                r_sh_l        <= r_hold_l;
                r_sh_r        <= r_hold_r;
                r_frame_start <= 1'b1;
                r_underrun    <= ~r_hold_full;
                r_hold_full   <= 1'b0;
            end

            // Placed after the load so a coincident write keeps the
            // register full; the load above still sees the old pair.
            if (sample_valid) begin
                r_hold_l    <= sample_l;
                r_hold_r    <= sample_r;
                r_hold_full <= 1'b1;
                r_overrun   <= r_hold_full && !w_load;
            end
        end
    end

    assign bclk        = r_bclk;
    assign lrclk       = r_lrclk;
    assign sdata       = r_sdata;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer
//   Self-checking bench for i2s_tx_serializer (CLK_DIV=2, SLOT_W=32).
//   Expected outputs come from a frame-level reference: output timing is
//   derived arithmetically from the clk count since reset release, and the
//   holding register is modelled at sample-pair level.
module tb_i2s_tx_serializer;

    localparam int CD  = 2;
    localparam int SW  = 16;
    localparam int SL  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sample_l;
    logic [SW-1:0] sample_r;
    logic          sample_valid;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          frame_start;
    logic          underrun;
    logic          overrun;

    i2s_tx_serializer #(
        .CLK_DIV  (CD),
        .SAMPLE_W (SW),
        .SLOT_W   (SL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int unsigned   checks   = 0;
    int unsigned   failures = 0;

    // Reference state
    int unsigned   m_n;
    logic          m_full;
    logic [SW-1:0] m_hl, m_hr;
    logic [SW-1:0] m_cl, m_cr;

    // Words reassembled from the DUT's sdata stream
    logic [SW-1:0] cap_l, cap_r;
    logic [SW-1:0] tx_l, tx_r;

    logic [SW-1:0] p1_l, p1_r, p2_l, p2_r, p3_l, p3_r;

    function automatic int unsigned load_n(input int unsigned f);
        return 2 * CD * (2 * SL * f + 1);
    endfunction

    function automatic int unsigned done_n(input int unsigned f);
        return 2 * CD * (2 * SL * f + SL + SW + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, m_n, obs, exp);
        end
    endtask

    // One clk cycle: drive inputs, advance the reference across the edge,
    // then compare every output at the falling clk edge.
    task automatic cyc(input logic rst, input logic sv,
                       input logic [SW-1:0] l, input logic [SW-1:0] r);
        int unsigned k, p;
        logic fall, ld;
        logic e_bclk, e_lr, e_sd, e_fs, e_ur, e_or;
        reset        = rst;
        sample_valid = sv;
        sample_l     = l;
        sample_r     = r;
        @(posedge clk);
        k = 0;
        p = 0;
        fall = 1'b0;
        if (rst) begin
            m_n = 0; m_full = 1'b0;
            m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0;
            e_bclk = 1'b0; e_lr = 1'b1; e_sd = 1'b0;
            e_fs = 1'b0; e_ur = 1'b0; e_or = 1'b0;
        end else begin
            m_n++;
            fall = (m_n % (2 * CD)) == 0;
            k    = m_n / (2 * CD);
            p    = (k == 0) ? 0 : (k - 1) % (2 * SL);
            ld   = fall && (p == 0);
            e_fs = ld;
            e_ur = ld && !m_full;
            e_or = sv && m_full && !ld;
            if (ld) begin
                m_cl = m_hl;
                m_cr = m_hr;
            end
            if (sv) begin
                m_hl = l; m_hr = r; m_full = 1'b1;
            end else if (ld) begin
                m_full = 1'b0;
            end
            e_bclk = ((m_n / CD) % 2) == 1;
            e_lr   = (k == 0) || (p >= SL);
            e_sd   = 1'b0;
            if (k > 0 && p >= 1 && p <= SW)
                e_sd = m_cl[SW - p];
            else if (k > 0 && p >= SL + 1 && p <= SL + SW)
                e_sd = m_cr[SL + SW - p];
        end
        @(negedge clk);
        chk("bclk",        32'(bclk),        32'(e_bclk));
        chk("lrclk",       32'(lrclk),       32'(e_lr));
        chk("sdata",       32'(sdata),       32'(e_sd));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("underrun",    32'(underrun),    32'(e_ur));
        chk("overrun",     32'(overrun),     32'(e_or));
        if (rst) begin
            cap_l = '0; cap_r = '0; tx_l = '0; tx_r = '0;
        end else if (fall && k > 0) begin
            if (p >= 1 && p <= SW)           cap_l = {cap_l[SW-2:0], sdata};
            if (p >= SL + 1 && p <= SL + SW) cap_r = {cap_r[SW-2:0], sdata};
            if (p == SL + SW) begin
                tx_l = cap_l;
                tx_r = cap_r;
            end
        end
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic run_until(input int unsigned target);
        while (m_n < target) idle_cyc();
    endtask

    initial begin
        m_n = 0;
        p1_l = 16'($urandom); p1_r = 16'($urandom);
        p2_l = 16'($urandom); p2_r = 16'($urandom);
        p3_l = 16'($urandom); p3_r = 16'($urandom);

        // Reset, with a strobe that must be ignored
        for (int i = 0; i < 5; i++)
            cyc(1'b1, (i == 2), 16'($urandom), 16'($urandom));

        run_until(2);
        chk("first_bclk_rise", 32'(bclk), 32'd1);
        run_until(4);
        chk("first_load_lrclk", 32'(lrclk), 32'd0);
        chk("first_load_fs", 32'(frame_start), 32'd1);
        chk("first_load_ur", 32'(underrun), 32'd1);

        // Bit order
        run_until(10);
        cyc(1'b0, 1'b1, 16'hA5C3, 16'h8001);
        run_until(done_n(0));
        chk("frame0_l_zero", 32'(tx_l), 32'h0);
        chk("frame0_r_zero", 32'(tx_r), 32'h0);
        run_until(done_n(1));
        chk("bitorder_l", 32'(tx_l), 32'hA5C3);
        chk("bitorder_r", 32'(tx_r), 32'h8001);

        // Underrun: no write, frame 2 replays the pair
        run_until(load_n(2));
        chk("underrun_pulse", 32'(underrun), 32'd1);
        run_until(done_n(2));
        chk("replay_l", 32'(tx_l), 32'hA5C3);
        chk("replay_r", 32'(tx_r), 32'h8001);

        // Overrun: two writes 10 cycles apart inside frame 2
        run_until(719);
        cyc(1'b0, 1'b1, p1_l, p1_r);
        chk("overrun_p1", 32'(overrun), 32'd0);
        run_until(729);
        cyc(1'b0, 1'b1, p2_l, p2_r);
        chk("overrun_p2", 32'(overrun), 32'd1);

        // Coincidence: P3 written exactly on frame 3's load
        run_until(load_n(3) - 1);
        cyc(1'b0, 1'b1, p3_l, p3_r);
        chk("coinc_fs", 32'(frame_start), 32'd1);
        chk("coinc_or", 32'(overrun), 32'd0);
        chk("coinc_ur", 32'(underrun), 32'd0);
        run_until(done_n(3));
        chk("frame3_p2_l", 32'(tx_l), 32'(p2_l));
        chk("frame3_p2_r", 32'(tx_r), 32'(p2_r));
        run_until(done_n(4));
        chk("frame4_p3_l", 32'(tx_l), 32'(p3_l));
        chk("frame4_p3_r", 32'(tx_r), 32'(p3_r));

        // Random writes until left bit 7 of frame 8
        while (m_n < load_n(8) + 2 * CD * 8) begin
            if ($urandom_range(149) == 0)
                cyc(1'b0, 1'b1, 16'($urandom), 16'($urandom));
            else
                idle_cyc();
        end

        // Reset mid-frame, again with an ignored strobe
        for (int i = 0; i < 3; i++)
            cyc(1'b1, (i == 1), 16'($urandom), 16'($urandom));
        run_until(2);
        chk("rst2_bclk_rise", 32'(bclk), 32'd1);
        run_until(4);
        chk("rst2_load_fs", 32'(frame_start), 32'd1);
        chk("rst2_load_ur", 32'(underrun), 32'd1);
        run_until(done_n(0));
        chk("rst2_frame0_l", 32'(tx_l), 32'h0);
        chk("rst2_frame0_r", 32'(tx_r), 32'h0);
        run_until(load_n(1) + 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
